// File: rtl/mage_pkg.sv
// Shared types and helpers for the multi-bank data memory front end.
package mage_pkg;

    localparam int DMEM_N_PORTS   = 4;
    localparam int DMEM_N_BANKS   = 8;
    localparam int DMEM_BANK_SIZE = 256;
    localparam int DMEM_DW        = 32;
    localparam int DMEM_BW        = $clog2(DMEM_N_BANKS);
    localparam int DMEM_RW        = $clog2(DMEM_BANK_SIZE);
    localparam int DMEM_AW        = $clog2(DMEM_N_BANKS * DMEM_BANK_SIZE);

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_port_req_t;

    // Low-order interleave: consecutive words land in consecutive banks.
    function automatic logic [DMEM_BW-1:0] dmem_bank_of(input logic [DMEM_AW-1:0] addr);
        return DMEM_BW'(addr);
    endfunction

endpackage

// File: rtl/dmem_bank_arbiter_rr.sv
// Round-robin arbiter with its own pointer; search starts one past the last winner.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic [IW-1:0] rr_ptr;
    logic          found;
    int            cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (en_i && !found && req_i[IW'(cand)]) begin
                found             = 1'b1;
                gnt_o[IW'(cand)]  = 1'b1;
                idx_o             = IW'(cand);
            end
        end
    end

    // Pointer only moves on a grant so an idle bank keeps its fairness history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rr_ptr <= IW'(N_REQ - 1);
        else if (found)
            rr_ptr <= idx_o;
    end

endmodule

// File: rtl/dmem_bank_arbiter.sv
// Request-side front end of the banked data memory: address decode, per-bank
// round-robin arbitration, bank port muxing and 1-cycle read data return.
module dmem_bank_arbiter
    import mage_pkg::*;
#(
    parameter  int N_PORTS   = DMEM_N_PORTS,
    parameter  int N_BANKS   = DMEM_N_BANKS,
    parameter  int BANK_SIZE = DMEM_BANK_SIZE,
    parameter  int DW        = DMEM_DW,
    localparam int BW        = $clog2(N_BANKS),
    localparam int RW        = $clog2(BANK_SIZE),
    localparam int AW        = BW + RW,
    localparam int PW        = $clog2(N_PORTS)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_PORTS-1:0]               port_req_i,
    input  logic [N_PORTS-1:0]               port_we_i,
    input  logic [N_PORTS-1:0][AW-1:0]       port_addr_i,
    input  logic [N_PORTS-1:0][DW-1:0]       port_wdata_i,
    output logic [N_PORTS-1:0]               port_gnt_o,
    output logic [N_PORTS-1:0]               port_rvalid_o,
    output logic [N_PORTS-1:0][DW-1:0]       port_rdata_o,
    output logic [N_BANKS-1:0]               dmem_req_o,
    output logic [N_BANKS-1:0]               dmem_we_o,
    output logic [N_BANKS-1:0]               dmem_be_o,
    output logic [N_BANKS-1:0][RW-1:0]       dmem_addr_o,
    output logic [N_BANKS-1:0][DW-1:0]       dmem_wdata_o,
    input  logic [N_BANKS-1:0][DW-1:0]       dmem_rdata_i
);

    dmem_port_req_t [N_PORTS-1:0]          port_req_s;
    logic [N_PORTS-1:0][BW-1:0]            port_bank;
    logic [N_BANKS-1:0][N_PORTS-1:0]       bank_req;
    logic [N_BANKS-1:0][N_PORTS-1:0]       bank_gnt;
    logic [N_BANKS-1:0][PW-1:0]            bank_idx;
    logic [N_PORTS-1:0]                    rd_pend;
    logic [N_PORTS-1:0][BW-1:0]            rd_bank;

    always_comb begin
        port_req_s = '0;
        port_bank  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            port_req_s[p].we    = port_we_i[p];
            port_req_s[p].addr  = port_addr_i[p];
            port_req_s[p].wdata = port_wdata_i[p];
            port_bank[p]        = dmem_bank_of(port_req_s[p].addr);
        end
    end

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < N_BANKS; b++)
            for (int p = 0; p < N_PORTS; p++)
                bank_req[b][p] = port_req_i[p] && (port_bank[p] == BW'(b));
    end

    // Arbiters are disabled during reset so grants and bank requests stay low.
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        rr_arbiter #(.N_REQ(N_PORTS)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (!rst_i),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b]),
            .idx_o (bank_idx[b])
        );
    end

    always_comb begin
        dmem_req_o   = '0;
        dmem_we_o    = '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (|bank_gnt[b]) begin
                dmem_req_o[b]   = 1'b1;
                dmem_we_o[b]    = port_req_s[bank_idx[b]].we;
                dmem_addr_o[b]  = port_req_s[bank_idx[b]].addr[AW-1:BW];
                dmem_wdata_o[b] = port_req_s[bank_idx[b]].wdata;
            end
        end
    end

    assign dmem_be_o = '1;

    always_comb begin
        port_gnt_o = '0;
        for (int p = 0; p < N_PORTS; p++)
            port_gnt_o[p] = bank_gnt[port_bank[p]][p];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend <= '0;
            rd_bank <= '0;
        end else begin
            rd_pend <= port_gnt_o & ~port_we_i;
            rd_bank <= port_bank;
        end
    end

    always_comb begin
        port_rvalid_o = rd_pend;
        port_rdata_o  = '0;
        for (int p = 0; p < N_PORTS; p++)
            if (rd_pend[p])
                port_rdata_o[p] = dmem_rdata_i[rd_bank[p]];
    end

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Bench for dmem_bank_arbiter: SRAM behavioural model plus a reference
// arbitration/scoreboard model derived from the round-robin rules.
module tb_dmem_bank_arbiter;

    localparam int NP = 4;
    localparam int NB = 8;
    localparam int BS = 256;
    localparam int DW = 32;
    localparam int RW = 8;
    localparam int AW = 11;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NP-1:0]           port_req = '0;
    logic [NP-1:0]           port_we = '0;
    logic [NP-1:0][AW-1:0]   port_addr = '0;
    logic [NP-1:0][DW-1:0]   port_wdata = '0;
    logic [NP-1:0]           port_gnt;
    logic [NP-1:0]           port_rvalid;
    logic [NP-1:0][DW-1:0]   port_rdata;
    logic [NB-1:0]           dmem_req;
    logic [NB-1:0]           dmem_we;
    logic [NB-1:0]           dmem_be;
    logic [NB-1:0][RW-1:0]   dmem_addr;
    logic [NB-1:0][DW-1:0]   dmem_wdata;
    logic [NB-1:0][DW-1:0]   dmem_rdata;

    dmem_bank_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .port_req_i    (port_req),
        .port_we_i     (port_we),
        .port_addr_i   (port_addr),
        .port_wdata_i  (port_wdata),
        .port_gnt_o    (port_gnt),
        .port_rvalid_o (port_rvalid),
        .port_rdata_o  (port_rdata),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_be_o     (dmem_be),
        .dmem_addr_o   (dmem_addr),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_rdata_i  (dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int a);
        return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    // SRAM banks: 1-cycle read latency, unwritten words hold a known pattern.
    logic [DW-1:0] sram [NB*BS];
    bit            sram_wr [NB*BS];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (dmem_req[b]) begin
                if (dmem_we[b]) begin
                    sram[int'(dmem_addr[b]) * NB + b]    <= dmem_wdata[b];
                    sram_wr[int'(dmem_addr[b]) * NB + b] <= 1'b1;
                end else begin
                    dmem_rdata[b] <= sram_wr[int'(dmem_addr[b]) * NB + b] ?
                                     sram[int'(dmem_addr[b]) * NB + b] :
                                     init_word(int'(dmem_addr[b]) * NB + b);
                end
            end
        end
    end

    int            compared = 0;
    int            mismatched = 0;
    logic [DW-1:0] ref_mem [NB*BS];
    int            rr_last [NB];
    int            win [NB];
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rvalid;
    logic [DW-1:0] exp_rdata [NP];
    logic [NB-1:0] exp_dreq;
    logic [NB-1:0] exp_dwe;
    logic [RW-1:0] exp_row [NB];
    logic [DW-1:0] exp_dwd [NB];

    task automatic model_reset();
        for (int b = 0; b < NB; b++) rr_last[b] = NP - 1;
        exp_rvalid = '0;
        for (int p = 0; p < NP; p++) exp_rdata[p] = '0;
    endtask

    // Each bank grants the first requesting port found after its last winner.
    task automatic model_eval();
        exp_gnt  = '0;
        exp_dreq = '0;
        exp_dwe  = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1; exp_row[b] = '0; exp_dwd[b] = '0;
        end
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (rr_last[b] + k) % NP;
                    if (win[b] < 0 && port_req[p] && (int'(port_addr[p]) % NB) == b) win[b] = p;
                end
                if (win[b] >= 0) begin
                    exp_gnt[win[b]] = 1'b1;
                    exp_dreq[b]     = 1'b1;
                    exp_dwe[b]      = port_we[win[b]];
                    exp_row[b]      = RW'(int'(port_addr[win[b]]) / NB);
                    exp_dwd[b]      = port_wdata[win[b]];
                end
            end
        end
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic advance();
        logic [NP-1:0] nv;
        logic [DW-1:0] nd [NP];
        model_eval();
        nv = '0;
        for (int p = 0; p < NP; p++) nd[p] = '0;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (exp_gnt[p]) begin
                    if (port_we[p]) ref_mem[int'(port_addr[p])] = port_wdata[p];
                    else begin
                        nv[p] = 1'b1;
                        nd[p] = ref_mem[int'(port_addr[p])];
                    end
                end
            end
            for (int b = 0; b < NB; b++) if (win[b] >= 0) rr_last[b] = win[b];
        end
        @(posedge clk);
        exp_rvalid = nv;
        for (int p = 0; p < NP; p++) exp_rdata[p] = nd[p];
        @(negedge clk);
    endtask

    task automatic set_req(int p, bit we, int addr, logic [DW-1:0] wd);
        port_req[p]   = 1'b1;
        port_we[p]    = we;
        port_addr[p]  = AW'(addr);
        port_wdata[p] = wd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, p, '0);
        #1;
        compared++; if (port_gnt !== '0) begin mismatched++; $display("FAIL reset_gnt: got %b expected 0", port_gnt); end
        compared++; if (dmem_req !== '0) begin mismatched++; $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); end
        compared++; if (port_rvalid !== '0) begin mismatched++; $display("FAIL reset_rvalid: got %b expected 0", port_rvalid); end
        @(negedge clk);
        rst = 1'b0; model_reset(); port_req = '0;
        set_req(0, 1'b0, 7, '0);
        advance();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, p + NB, '0);
        #2 rst = 1'b1;
        #1;
        compared++; if (port_rvalid !== '0) begin mismatched++; $display("FAIL reset_midstream_rvalid: got %b expected 0", port_rvalid); end
        compared++; if (port_gnt !== '0) begin mismatched++; $display("FAIL reset_midstream_gnt: got %b expected 0", port_gnt); end
        compared++; if (dmem_req !== '0) begin mismatched++; $display("FAIL reset_midstream_dmem_req: got %b expected 0", dmem_req); end
        compared++; if (port_rdata[0] !== '0) begin mismatched++; $display("FAIL reset_midstream_rdata: got %h expected 0", port_rdata[0]); end
        @(negedge clk); #1;
        compared++; if (port_rvalid !== '0) begin mismatched++; $display("FAIL reset_next_rvalid: got %b expected 0", port_rvalid); end
        @(negedge clk);
        rst = 1'b0; model_reset(); port_req = '0;
    endtask

    task automatic test_distinct();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, p, '0);
        #1;
        compared++; if (port_gnt !== 4'hF) begin mismatched++; $display("FAIL distinct_gnt: got %b expected 1111", port_gnt); end
        compared++; if (dmem_req !== 8'h0F) begin mismatched++; $display("FAIL distinct_dmem_req: got %b expected 00001111", dmem_req); end
        for (int b = 0; b < 4; b++) begin
            compared++; if (dmem_addr[b] !== '0) begin mismatched++; $display("FAIL distinct_addr[%0d]: got %h expected 0", b, dmem_addr[b]); end
        end
        advance();
        port_req = '0;
        #1;
        compared++; if (port_rvalid !== 4'hF) begin mismatched++; $display("FAIL distinct_rvalid: got %b expected 1111", port_rvalid); end
        for (int p = 0; p < NP; p++) begin
            compared++; if (port_rdata[p] !== ref_mem[p]) begin mismatched++; $display("FAIL distinct_rdata[%0d]: got %h expected %h", p, port_rdata[p], ref_mem[p]); end
        end
        advance();
    endtask

    task automatic test_conflict();
        int order [5];
        logic [NP-1:0] exp_rv;
        order = '{0, 1, 2, 3, 0};
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, int'($urandom_range(0, BS - 1)) * NB + 5, '0);
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_rv = (c == 0) ? '0 : NP'(1 << order[(c > 0) ? c - 1 : 0]);
            compared++; if (port_gnt !== NP'(1 << order[c])) begin mismatched++; $display("FAIL conflict_gnt[%0d]: got %b expected %b", c, port_gnt, NP'(1 << order[c])); end
            compared++; if (port_rvalid !== exp_rv) begin mismatched++; $display("FAIL conflict_rvalid[%0d]: got %b expected %b", c, port_rvalid, exp_rv); end
            if (c > 0) begin
                compared++; if (port_rdata[order[c-1]] !== exp_rdata[order[c-1]]) begin mismatched++; $display("FAIL conflict_rdata[%0d]: got %h expected %h", c, port_rdata[order[c-1]], exp_rdata[order[c-1]]); end
            end
            advance();
            for (int p = 0; p < NP; p++)
                if (exp_gnt[p]) set_req(p, 1'b0, int'($urandom_range(0, BS - 1)) * NB + 5, '0);
        end
        port_req = '0;
        advance();
    endtask

    task automatic test_write_read();
        set_req(2, 1'b1, 'h4B, 32'hDEADBEEF);
        #1;
        compared++; if (port_gnt !== 4'b0100) begin mismatched++; $display("FAIL wr_gnt: got %b expected 0100", port_gnt); end
        compared++; if (dmem_req[3] !== 1'b1) begin mismatched++; $display("FAIL wr_dmem_req3: got %b expected 1", dmem_req[3]); end
        compared++; if (dmem_addr[3] !== 8'h09) begin mismatched++; $display("FAIL wr_row: got %h expected 09", dmem_addr[3]); end
        compared++; if (dmem_we[3] !== 1'b1) begin mismatched++; $display("FAIL wr_we: got %b expected 1", dmem_we[3]); end
        compared++; if (dmem_wdata[3] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_wdata: got %h expected deadbeef", dmem_wdata[3]); end
        advance();
        set_req(2, 1'b0, 'h4B, '0);
        #1;
        compared++; if (port_rvalid !== '0) begin mismatched++; $display("FAIL wr_no_rvalid: got %b expected 0", port_rvalid); end
        advance();
        port_req = '0;
        #1;
        compared++; if (port_rvalid !== 4'b0100) begin mismatched++; $display("FAIL rd_rvalid: got %b expected 0100", port_rvalid); end
        compared++; if (port_rdata[2] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_rdata: got %h expected deadbeef", port_rdata[2]); end
        advance();
    endtask

    task automatic test_fairness();
        int gap;
        int per_bank [NB];
        bit multi;
        gap = 0;
        set_req(1, 1'b0, int'($urandom_range(0, BS - 1)) * NB, '0);
        for (int c = 0; c < 40; c++) begin
            for (int p = 0; p < NP; p++)
                if (p != 1 && !port_req[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, BS - 1)) * NB, $urandom);
            model_eval();
            #1;
            compared++; if (port_gnt !== exp_gnt) begin mismatched++; $display("FAIL fair_gnt[%0d]: got %b expected %b", c, port_gnt, exp_gnt); end
            compared++; if ((port_gnt & ~port_req) !== '0) begin mismatched++; $display("FAIL fair_gnt_without_req[%0d]: got %b req %b", c, port_gnt, port_req); end
            for (int b = 0; b < NB; b++) per_bank[b] = 0;
            for (int p = 0; p < NP; p++) if (port_gnt[p]) per_bank[int'(port_addr[p]) % NB]++;
            multi = 1'b0;
            for (int b = 0; b < NB; b++) if (per_bank[b] > 1) multi = 1'b1;
            compared++; if (multi) begin mismatched++; $display("FAIL fair_multi_gnt[%0d]: got %b expected at most one per bank", c, port_gnt); end
            compared++; if (port_rvalid !== exp_rvalid) begin mismatched++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", c, port_rvalid, exp_rvalid); end
            for (int p = 0; p < NP; p++) begin
                compared++; if (port_rdata[p] !== exp_rdata[p]) begin mismatched++; $display("FAIL fair_rdata[%0d][%0d]: got %h expected %h", c, p, port_rdata[p], exp_rdata[p]); end
            end
            if (port_gnt[1]) gap = 0; else gap++;
            compared++; if (gap > 3) begin mismatched++; $display("FAIL fair_port1_starved[%0d]: got %0d idle cycles expected <= 3", c, gap); end
            advance();
            for (int p = 0; p < NP; p++) begin
                if (exp_gnt[p]) begin
                    if (p == 1) set_req(1, 1'b0, int'($urandom_range(0, BS - 1)) * NB, '0);
                    else port_req[p] = 1'b0;
                end
            end
        end
        port_req = '0;
        advance();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 150; c++) begin
            for (int p = 0; p < NP; p++)
                if (!port_req[p] && $urandom_range(0, 3) != 0)
                    set_req(p, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, BS - 1)) * NB + int'($urandom_range(0, 3)), $urandom);
            model_eval();
            #1;
            compared++; if (port_gnt !== exp_gnt) begin mismatched++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", c, port_gnt, exp_gnt); end
            compared++; if (dmem_req !== exp_dreq) begin mismatched++; $display("FAIL b2b_dmem_req[%0d]: got %b expected %b", c, dmem_req, exp_dreq); end
            compared++; if (dmem_we !== exp_dwe) begin mismatched++; $display("FAIL b2b_dmem_we[%0d]: got %b expected %b", c, dmem_we, exp_dwe); end
            for (int b = 0; b < NB; b++) begin
                compared++; if (dmem_addr[b] !== exp_row[b]) begin mismatched++; $display("FAIL b2b_addr[%0d][%0d]: got %h expected %h", c, b, dmem_addr[b], exp_row[b]); end
                compared++; if (dmem_wdata[b] !== exp_dwd[b]) begin mismatched++; $display("FAIL b2b_wdata[%0d][%0d]: got %h expected %h", c, b, dmem_wdata[b], exp_dwd[b]); end
            end
            compared++; if (port_rvalid !== exp_rvalid) begin mismatched++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", c, port_rvalid, exp_rvalid); end
            for (int p = 0; p < NP; p++) begin
                compared++; if (port_rdata[p] !== exp_rdata[p]) begin mismatched++; $display("FAIL b2b_rdata[%0d][%0d]: got %h expected %h", c, p, port_rdata[p], exp_rdata[p]); end
            end
            advance();
            for (int p = 0; p < NP; p++) if (exp_gnt[p]) port_req[p] = 1'b0;
        end
        port_req = '0;
        advance();
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, (p + 1) * NB + 2, '0);
        advance();
        set_req(0, 1'b0, 20 * NB + 2, '0);
        advance();
        set_req(1, 1'b0, 21 * NB + 2, '0);
        model_eval();
        #1;
        compared++; if (port_gnt !== exp_gnt) begin mismatched++; $display("FAIL areset_pre_gnt: got %b expected %b", port_gnt, exp_gnt); end
        #2 rst = 1'b1;
        #1;
        compared++; if (port_gnt !== '0) begin mismatched++; $display("FAIL areset_gnt: got %b expected 0", port_gnt); end
        compared++; if (dmem_req !== '0) begin mismatched++; $display("FAIL areset_dmem_req: got %b expected 0", dmem_req); end
        compared++; if (port_rvalid !== '0) begin mismatched++; $display("FAIL areset_rvalid: got %b expected 0", port_rvalid); end
        @(negedge clk);
        rst = 1'b0; model_reset();
        #1;
        compared++; if (port_gnt !== 4'b0001) begin mismatched++; $display("FAIL areset_first_winner: got %b expected 0001", port_gnt); end
        advance();
        port_req = '0;
        advance();
    endtask

    initial begin
        for (int i = 0; i < NB * BS; i++) ref_mem[i] = init_word(i);
        model_reset();
        test_reset();
        test_distinct();
        test_conflict();
        test_write_read();
        test_fairness();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
